cache_req_master: RTL and testbench

//  Requester-side engine for the cache_controller port (addr/wr_en/rd_en/data_in -> data_out/hit).

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_req_fifo.sv | 43 ++++
 rtl/cache_req_master.sv | 154 +++++++++++++++
 tb/tb_cache_req_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache requester: FSM encoding, default widths and
// the packed layout of one buffered request.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int RETRY_W        = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Entry layout, MSB first: {write, addr, wdata}
  function automatic int entry_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Request FIFO: registered storage with full/empty derived from pointers that
// carry one extra wrap bit.
module cache_req_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cache_req_master.sv
// Requester engine for cache_controller: buffers requests, strobes the cache
// once per attempt, retries read misses and returns one response per request.
module cache_req_master
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic [RETRY_W-1:0]    resp_retries,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_wr_en,
  output logic                  cache_rd_en,
  output logic [DATA_WIDTH-1:0] cache_data_in,
  input  logic [DATA_WIDTH-1:0] cache_data_out,
  input  logic                  cache_hit,
  output logic                  busy
);

  localparam int               ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic [RETRY_W-1:0]    rretry_q, rretry_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  cache_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (req_valid),
    .wdata_i ({req_write, req_addr, req_wdata}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req_ready     = !fifo_full;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;
  assign cache_addr    = addr_q;
  assign cache_data_in = data_q;
  assign cache_wr_en   = (state_q == S_ISSUE) && wr_q;
  assign cache_rd_en   = (state_q == S_ISSUE) && !wr_q;
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_hit      = hit_q;
  assign resp_retries  = rretry_q;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    retry_d  = retry_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    rretry_d = rretry_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          wr_d     = fifo_head[ENTRY_W-1];
          addr_d   = fifo_head[ENTRY_W-2 -: ADDR_WIDTH];
          data_d   = fifo_head[DATA_WIDTH-1:0];
          retry_d  = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          rdata_d  = '0;
          hit_d    = 1'b1;
          rretry_d = retry_q;
          state_d  = S_RESP;
        end else begin
          state_d  = S_WAIT;
        end
      end
      // Cache outputs are registered: give them one cycle before sampling.
      S_WAIT: state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (cache_hit) begin
          rdata_d  = cache_data_out;
          hit_d    = 1'b1;
          rretry_d = retry_q;
          state_d  = S_RESP;
        end else if (retry_q < MAX_R) begin
          retry_d  = sat_inc(retry_q);
          state_d  = S_ISSUE;
        end else begin
          rdata_d  = '0;
          hit_d    = 1'b0;
          rretry_d = retry_q;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      retry_q  <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      rretry_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      rretry_q <= rretry_d;
    end
  end

endmodule

// File: tb/tb_cache_req_master.sv
// Directed bench for cache_req_master with a small behavioural cache model.
module tb_cache_req_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic [2:0]  resp_retries;
  logic [7:0]  cache_addr;
  logic        cache_wr_en, cache_rd_en;
  logic [31:0] cache_data_in;
  logic [31:0] cache_data_out = '0;
  logic        cache_hit = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Cache model controls
  int          miss_left = 0;
  logic        addr_mode = 1'b0;
  logic [31:0] hit_data  = '0;

  int cyc = 0, rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0;
  int rd_last = 0, rd_prev = 0;
  logic [31:0] mon_rdata[$];
  logic        mon_hit[$];

  cache_req_master #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .MAX_RETRY  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_hit       (resp_hit),
    .resp_retries   (resp_retries),
    .cache_addr     (cache_addr),
    .cache_wr_en    (cache_wr_en),
    .cache_rd_en    (cache_rd_en),
    .cache_data_in  (cache_data_in),
    .cache_data_out (cache_data_out),
    .cache_hit      (cache_hit),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cache_rd_en && cache_wr_en) overlap_cnt <= overlap_cnt + 1;
    if (cache_wr_en) wr_cnt <= wr_cnt + 1;
    if (cache_rd_en) begin
      rd_cnt  <= rd_cnt + 1;
      rd_prev <= rd_last;
      rd_last <= cyc;
      if (miss_left > 0) begin
        miss_left      <= miss_left - 1;
        cache_hit      <= 1'b0;
        cache_data_out <= 32'hBAD0_BAD0;
      end else begin
        cache_hit      <= 1'b1;
        cache_data_out <= addr_mode ? (32'h0000_1000 + {24'd0, cache_addr}) : hit_data;
      end
    end
    if (rst && resp_valid && resp_ready) begin
      mon_rdata.push_back(resp_rdata);
      mon_hit.push_back(resp_hit);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d, output int stalls);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    stalls    = 0;
    while (!req_ready && stalls < 100) begin
      tick();
      stalls++;
    end
    if (!req_ready) check("push_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    if (!resp_valid) check("resp_timeout", 0, 1);
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    int st, lat, rd0, bad, n0;

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_outputs", {resp_valid, cache_wr_en, cache_rd_en, busy, resp_hit}, 0);
    check("rst_data", {resp_rdata, cache_data_in, cache_addr, resp_retries}, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: single write
    push(1'b1, 8'hAA, 32'h0000_DEAD, st);
    tick();
    check("t1_issue_strobes", {cache_wr_en, cache_rd_en}, 2'b10);
    check("t1_issue_addr", cache_addr, 8'hAA);
    check("t1_issue_data", cache_data_in, 32'h0000_DEAD);
    tick();
    check("t1_resp_valid", resp_valid, 1);
    check("t1_strobe_off", cache_wr_en, 0);
    check("t1_payload", {resp_hit, resp_rdata, resp_retries}, {1'b1, 32'h0, 3'd0});
    check("t1_wr_pulses", wr_cnt, 1);
    accept();
    check("t1_resp_released", resp_valid, 0);

    // 2: read, one miss then hit
    miss_left = 1; hit_data = 32'h0000_DEAD; rd0 = rd_cnt;
    push(1'b0, 8'hAA, 32'h0, st);
    wait_resp(lat);
    check("t2_latency", lat, 7);
    check("t2_rd_pulses", rd_cnt - rd0, 2);
    check("t2_pulse_gap", rd_last - rd_prev, 3);
    check("t2_payload", {resp_hit, resp_rdata, resp_retries}, {1'b1, 32'h0000_DEAD, 3'd1});
    accept();

    // 3: read, always missing
    miss_left = 1000; rd0 = rd_cnt;
    push(1'b0, 8'hCC, 32'h0, st);
    wait_resp(lat);
    check("t3_latency", lat, 10);
    check("t3_rd_pulses", rd_cnt - rd0, 3);
    check("t3_payload", {resp_hit, resp_rdata, resp_retries}, {1'b0, 32'h0, 3'd2});
    accept();
    miss_left = 0;

    // 4: back-to-back reads; the head is popped at once so five fit before full
    addr_mode = 1'b1; n0 = mon_rdata.size();
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 8'h10 + 8'(i), 32'h0, st);
      check($sformatf("t4_push%0d_stall", i), st, 0);
    end
    check("t4_full_ready", req_ready, 0);
    push(1'b0, 8'h15, 32'h0, st);
    check("t4_push5_stall", st, 2);
    for (int i = 0; i < 200 && mon_rdata.size() < n0 + 6; i++) tick();
    check("t4_resp_count", mon_rdata.size() - n0, 6);
    for (int i = 0; i < 6; i++) begin
      if (mon_rdata.size() > n0 + i)
        check($sformatf("t4_order%0d", i), {mon_hit[n0+i], mon_rdata[n0+i]},
              {1'b1, 32'h0000_1010 + 32'(i)});
    end
    resp_ready = 1'b0;
    addr_mode  = 1'b0;

    // 5: backpressure on a read hit
    hit_data = 32'h0000_CAFE; n0 = mon_rdata.size();
    push(1'b0, 8'h33, 32'h0, st);
    wait_resp(lat);
    check("t5_latency", lat, 4);
    rd0 = rd_cnt; bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!resp_valid || resp_rdata !== 32'h0000_CAFE || resp_hit !== 1'b1 || resp_retries !== 3'd0)
        bad++;
    end
    check("t5_held_stable", bad, 0);
    check("t5_no_strobe", rd_cnt - rd0 + (cache_wr_en | cache_rd_en), 0);
    accept();
    check("t5_one_resp", mon_rdata.size() - n0, 1);
    check("t5_released", resp_valid, 0);

    // 6: reset during WAIT, with a second request still buffered
    n0 = mon_rdata.size();
    push(1'b0, 8'h44, 32'h0, st);
    push(1'b0, 8'h45, 32'h0, st);
    tick();
    check("t6_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_strobes", {cache_wr_en, cache_rd_en, resp_valid}, 0);
    check("t6_ready_idle", {req_ready, busy}, 2'b10);
    tick();
    rst = 1'b1;
    rd0 = rd_cnt;
    resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t6_no_resp", mon_rdata.size() - n0, 0);
    check("t6_no_access", rd_cnt - rd0, 0);
    resp_ready = 1'b0;

    check("no_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
